// File: rtl/sum_accumulator_32bit_pkg.sv
// Shared definitions for the sum accumulator: FSM encoding, default sizing
// and the carry-detect helper used on the accumulator path.
package sum_accumulator_32bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_N_OPS = 4;
  localparam int DEF_CNT_W = 8;

  // A modular add wrapped past 2^32 exactly when the result is below an operand.
  function automatic logic carry_out(input logic [31:0] a, input logic [31:0] sum);
    return (sum < a);
  endfunction

endpackage

// File: rtl/sum_accumulator_32bit_adder.sv
// Plain 32-bit modulo adder feeding the accumulator register.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/sum_accumulator_32bit.sv
// Frame accumulator: sums up to N_OPS beats (or until in_last), then holds
// total, beat count and sticky carry on a valid/ready result port.
module sum_accumulator_32bit
  import sum_accumulator_32bit_pkg::*;
#(
  parameter int N_OPS = DEF_N_OPS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid && ready; valid holds its data until that edge, ready may depend on state only.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS);

  state_t           state, state_next;
  logic [31:0]      acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             ovf, carry;
  logic             in_fire, out_fire, frame_close;

  adder_32bit u_acc_add (
    .a  (acc),
    .b  (in_data),
    .sum(acc_next)
  );

  assign carry       = carry_out(acc, acc_next);
  assign cnt_inc     = cnt + CNT_W'(1);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign frame_close = in_fire && ((cnt_inc == LAST_CNT) || in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (frame_close)  state_next = ST_DONE;
        else if (in_fire) state_next = ST_ACCUM;
      end
      ST_DONE: begin
        if (out_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != ST_DONE);
  end

  // acc/cnt/ovf hold through DONE and clear only when the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (in_fire) begin
      acc <= acc_next;
      cnt <= cnt_inc;
      ovf <= ovf | carry;
    end else if (out_fire) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (frame_close) begin
      out_valid <= 1'b1;
      out_sum   <= acc_next;
      out_count <= cnt_inc;
      out_ovf   <= ovf | carry;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accumulator_32bit.sv
// Bench for sum_accumulator_32bit: directed frames with literal results plus a
// randomized run scored against a frame-level model of the accumulator.
module tb_sum_accumulator_32bit;

  localparam int N_OPS = 4;
  localparam int CNT_W = 8;
  localparam int W     = 32 + CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready, out_valid, out_ovf;
  logic [31:0]      out_sum;
  logic [CNT_W-1:0] out_count;

  sum_accumulator_32bit #(.N_OPS(N_OPS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  // Single-beat-frame instance.
  logic             v1 = 1'b0;
  logic [31:0]      d1 = '0;
  logic             r1, ov1, ovf1;
  logic [31:0]      s1;
  logic [CNT_W-1:0] c1;

  sum_accumulator_32bit #(.N_OPS(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1), .in_data(d1), .in_last(1'b0),
    .out_valid(ov1), .out_ready(1'b1),
    .out_sum(s1), .out_count(c1), .out_ovf(ovf1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  beats_q[$];
  bit           model_on = 1'b0;
  int           frames_out = 0;

  function automatic logic [W-1:0] frame_result(input logic [31:0] beats[$]);
    longint unsigned total = 0;
    foreach (beats[i]) total += beats[i];
    // A carry happened somewhere iff the true (unwrapped) total reached 2^32.
    return {total[31:0], CNT_W'(beats.size()), (total >= 64'h1_0000_0000)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", {out_sum, out_count, out_ovf}, 0);
      exp_q.delete();
      beats_q.delete();
    end else if (model_on) begin
      check("in_ready", in_ready, exp_q.size() == 0);
      check("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_data", {out_sum, out_count, out_ovf}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          frames_out++;
        end
      end else if (in_valid) begin
        beats_q.push_back(in_data);
        if (beats_q.size() == N_OPS || in_last) begin
          exp_q.push_back(frame_result(beats_q));
          beats_q.delete();
        end
      end
    end
  end

  // Upstream must hold its beat steady while it is being stalled.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;
  always @(posedge clk) begin
    if (rst_n && prev_stall)
      assert (in_valid && {in_last, in_data} == prev_beat)
        else $error("in_data changed while stalled");
    prev_stall <= rst_n && in_valid && !in_ready;
    prev_beat  <= {in_last, in_data};
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [31:0] d, input logic l);
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit rand_or = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int len;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);
    model_on = 1'b1;
    out_ready = 1'b1;

    // Basic frame, result shown for exactly one cycle.
    for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 10);
    check("t1_count", out_count, 4);
    check("t1_ovf", out_ovf, 0);
    tick();
    check("t1_valid_drop", out_valid, 0);

    // Carry, then a clean frame clears the sticky flag.
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h0, 1'b0);
    send_beat(32'h0, 1'b0);
    check("t2_sum", out_sum, 1);
    check("t2_ovf", out_ovf, 1);
    tick();
    for (int i = 0; i < 4; i++) send_beat(32'h1, 1'b0);
    check("t2_sum2", out_sum, 4);
    check("t2_ovf2", out_ovf, 0);
    tick();

    // Early close with in_last.
    send_beat(32'd5, 1'b0);
    send_beat(32'd7, 1'b1);
    check("t3_valid", out_valid, 1);
    check("t3_sum", out_sum, 12);
    check("t3_count", out_count, 2);
    tick();

    // Backpressure on the result port.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(32'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd100;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_in_ready_low", in_ready, 0);
      check("t4_hold", {out_valid, out_sum, out_count}, {1'b1, 32'd10, 8'd4});
    end
    out_ready = 1'b1;
    tick();
    check("t4_after_hs_valid", out_valid, 0);
    check("t4_after_hs_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t4_next_frame", {out_valid, out_sum, out_count}, {1'b1, 32'd100, 8'd1});
    tick();

    // Reset mid-frame discards the partial frame.
    send_beat(32'd50, 1'b0);
    send_beat(32'd60, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_beat(32'd9, 1'b0);
    check("t5_sum", out_sum, 36);
    check("t5_count", out_count, 4);
    check("t5_ovf", out_ovf, 0);
    tick();

    // N_OPS == 1: every beat is its own frame.
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      v1 = 1'b1;
      d1 = d;
      tick();
      v1 = 1'b0;
      check("n1_result", {ov1, s1, c1, ovf1}, {1'b1, d, 8'd1, 1'b0});
      tick();
      check("n1_released", {ov1, r1}, 2'b01);
    end

    // Random frames, gaps and result backpressure.
    frames_out = 0;
    rand_or = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, N_OPS);
      for (int b = 0; b < len; b++) begin
        while ($urandom_range(0, 3) != 0) tick();
        d = ($urandom_range(0, 3) == 0) ? 32'hF000_0000 | $urandom : $urandom_range(0, 1000);
        send_beat(d, (b == len - 1) && (len < N_OPS || $urandom_range(0, 1) == 1));
      end
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    rand_or = 1'b0;
    #2;
    out_ready = 1'b1;
    check("drain_empty", exp_q.size(), 0);
    check("frames_out", frames_out, 200);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
